// File: rtl/ysyx_22040759_wbctrl_if.sv
// Issue, write-back request and register-file write-port bundle for ysyx_22040759_wbctrl.
// master = issue stage / execution units side, slave = the controller.
interface ysyx_22040759_wbctrl_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREQ = 3
);
  logic                   iss_valid;
  logic                   iss_wen;
  logic [4:0]             iss_rd;
  logic [4:0]             iss_rs1;
  logic [4:0]             iss_rs2;
  logic                   iss_stall;
  logic [NREQ-1:0]        req_valid;
  logic [5*NREQ-1:0]      req_rd;
  logic [XLEN*NREQ-1:0]   req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   gpr_wen;
  logic [4:0]             gpr_waddr;
  logic [XLEN-1:0]        gpr_wdata;
  logic                   fwd1_hit;
  logic                   fwd2_hit;
  logic [XLEN-1:0]        fwd_data;
  logic                   sb_err;

  modport master (
    output iss_valid, iss_wen, iss_rd, iss_rs1, iss_rs2, req_valid, req_rd, req_data,
    input  iss_stall, req_ready, gpr_wen, gpr_waddr, gpr_wdata, fwd1_hit, fwd2_hit,
           fwd_data, sb_err
  );

  modport slave (
    input  iss_valid, iss_wen, iss_rd, iss_rs1, iss_rs2, req_valid, req_rd, req_data,
    output iss_stall, req_ready, gpr_wen, gpr_waddr, gpr_wdata, fwd1_hit, fwd2_hit,
           fwd_data, sb_err
  );
endinterface

// File: rtl/ysyx_22040759_wbctrl.sv
// Write-back controller: round-robin arbitration of EXU/LSU/MDU onto the GPR write port plus
// a busy-bit scoreboard for RAW/WAW stalls. Define YSYX_22040759_WBCTRL_BYPASS_EN for bypass.
module ysyx_22040759_wbctrl #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREQ = 3
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_22040759_wbctrl_if.slave  bus
);

  logic [31:0]      busy_q, busy_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             gpr_wen_q, gpr_wen_d;
  logic [4:0]       gpr_waddr_q, gpr_waddr_d;
  logic [XLEN-1:0]  gpr_wdata_q, gpr_wdata_d;
  logic             sb_err_q, sb_err_d;

  logic [NREQ-1:0]  gnt;
  logic             gnt_any;
  logic [1:0]       gnt_idx;
  logic [2:0]       cand;
  logic [4:0]       sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic             hit1, hit2, stall, iss_fire;

  // Round-robin search starting at ptr_q, wrapping modulo 3.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    cand    = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, ptr_q} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!gnt_any && bus.req_valid[cand[1:0]]) begin
        gnt_any           = 1'b1;
        gnt_idx           = cand[1:0];
        gnt[cand[1:0]]    = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rd   = bus.req_rd[4:0];
    sel_data = bus.req_data[XLEN-1:0];
    case (gnt_idx)
      2'd1: begin
        sel_rd   = bus.req_rd[9:5];
        sel_data = bus.req_data[2*XLEN-1:XLEN];
      end
      2'd2: begin
        sel_rd   = bus.req_rd[14:10];
        sel_data = bus.req_data[3*XLEN-1:2*XLEN];
      end
      default: ;
    endcase
  end

`ifdef YSYX_22040759_WBCTRL_BYPASS_EN
  always_comb begin
    hit1 = gpr_wen_q & (gpr_waddr_q == bus.iss_rs1) & (bus.iss_rs1 != 5'd0);
    hit2 = gpr_wen_q & (gpr_waddr_q == bus.iss_rs2) & (bus.iss_rs2 != 5'd0);
  end
  assign bus.fwd_data = gpr_wdata_q;
`else
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
  end
  assign bus.fwd_data = '0;
`endif

  // WAW term is never masked by bypass: the older write must retire first.
  always_comb begin
    stall = bus.iss_valid & ((busy_q[bus.iss_rs1] & ~hit1) |
                             (busy_q[bus.iss_rs2] & ~hit2) |
                             (bus.iss_wen & busy_q[bus.iss_rd]));
    iss_fire = bus.iss_valid & ~stall;
  end

  always_comb begin
    busy_d = busy_q;
    if (iss_fire && bus.iss_wen && (bus.iss_rd != 5'd0)) busy_d[bus.iss_rd] = 1'b1;
    if (gpr_wen_q) busy_d[gpr_waddr_q] = 1'b0;
    busy_d[0] = 1'b0;

    ptr_d       = ptr_q;
    gpr_wen_d   = 1'b0;
    gpr_waddr_d = gpr_waddr_q;
    gpr_wdata_d = gpr_wdata_q;
    sb_err_d    = sb_err_q;
    if (gnt_any) begin
      ptr_d       = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
      gpr_wen_d   = (sel_rd != 5'd0);
      gpr_waddr_d = sel_rd;
      gpr_wdata_d = sel_data;
      if ((sel_rd != 5'd0) && !busy_q[sel_rd]) sb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      ptr_q       <= 2'd0;
      gpr_wen_q   <= 1'b0;
      gpr_waddr_q <= 5'd0;
      gpr_wdata_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      gpr_wen_q   <= gpr_wen_d;
      gpr_waddr_q <= gpr_waddr_d;
      gpr_wdata_q <= gpr_wdata_d;
      sb_err_q    <= sb_err_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.iss_stall = stall;
  assign bus.fwd1_hit  = hit1;
  assign bus.fwd2_hit  = hit2;
  assign bus.gpr_wen   = gpr_wen_q;
  assign bus.gpr_waddr = gpr_waddr_q;
  assign bus.gpr_wdata = gpr_wdata_q;
  assign bus.sb_err    = sb_err_q;

endmodule

// File: tb/tb_ysyx_22040759_wbctrl.sv
// Self-checking bench for ysyx_22040759_wbctrl: directed scenarios plus randomized traffic
// checked against a behavioural scoreboard/arbiter model.
module tb_ysyx_22040759_wbctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef YSYX_22040759_WBCTRL_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  ysyx_22040759_wbctrl_if bus ();

  ysyx_22040759_wbctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state.
  bit [31:0] m_busy;
  int        m_ptr;
  bit        m_wen;
  bit [4:0]  m_waddr;
  bit [63:0] m_wdata;
  bit        m_err;

  function automatic int f_grant();
    for (int k = 0; k < 3; k++) begin
      if (bus.req_valid[(m_ptr + k) % 3] === 1'b1) return (m_ptr + k) % 3;
    end
    return -1;
  endfunction

  function automatic bit f_hit(input logic [4:0] rs);
    return Byp && m_wen && (m_waddr == rs) && (rs != 5'd0);
  endfunction

  function automatic bit f_stall();
    if (bus.iss_valid !== 1'b1) return 1'b0;
    return (m_busy[bus.iss_rs1] && !f_hit(bus.iss_rs1)) ||
           (m_busy[bus.iss_rs2] && !f_hit(bus.iss_rs2)) ||
           (bus.iss_wen && m_busy[bus.iss_rd]);
  endfunction

  task automatic drive_iss(input bit v, input bit w, input int rd, input int rs1, input int rs2);
    bus.iss_valid = v;
    bus.iss_wen   = w;
    bus.iss_rd    = 5'(rd);
    bus.iss_rs1   = 5'(rs1);
    bus.iss_rs2   = 5'(rs2);
  endtask

  task automatic idle();
    drive_iss(0, 0, 0, 0, 0);
    bus.req_valid = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
  endtask

  // Advance one clock edge, updating the model from the inputs seen before the edge.
  task automatic tick();
    int g;
    bit fire, set_en;
    logic [4:0] rd, ird;
    logic [63:0] d;
    g      = f_grant();
    fire   = (bus.iss_valid === 1'b1) && !f_stall();
    set_en = fire && bus.iss_wen && (bus.iss_rd != 5'd0);
    ird    = bus.iss_rd;
    rd     = 5'd0;
    d      = 64'd0;
    if (g >= 0) begin
      rd = bus.req_rd[5*g +: 5];
      d  = bus.req_data[64*g +: 64];
    end
    @(posedge clk);
    if (rst) begin
      m_busy = '0; m_ptr = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_err = 0;
    end else begin
      if (g >= 0 && rd != 5'd0 && !m_busy[rd]) m_err = 1'b1;
      if (set_en) m_busy[ird] = 1'b1;
      if (m_wen) m_busy[m_waddr] = 1'b0;
      if (g >= 0) begin
        m_wen = (rd != 5'd0); m_waddr = rd; m_wdata = d; m_ptr = (g + 1) % 3;
      end else begin
        m_wen = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.gpr_wen !== 1'b0) $display("FAIL rst_wen got %b want 0", bus.gpr_wen); else n_pass++;
    n_checks++; if (bus.gpr_waddr !== 5'd0) $display("FAIL rst_waddr got %0d want 0", bus.gpr_waddr); else n_pass++;
    n_checks++; if (bus.gpr_wdata !== 64'd0) $display("FAIL rst_wdata got %h want 0", bus.gpr_wdata); else n_pass++;
    n_checks++; if (bus.sb_err !== 1'b0) $display("FAIL rst_sb_err got %b want 0", bus.sb_err); else n_pass++;
    drive_iss(1, 1, 5, 5, 5);
    bus.req_valid = 3'b110;
    #1;
    n_checks++; if (bus.iss_stall !== 1'b0) $display("FAIL rst_stall got %b want 0", bus.iss_stall); else n_pass++;
    n_checks++; if ({bus.fwd1_hit, bus.fwd2_hit} !== 2'b00) $display("FAIL rst_fwd got %b want 00", {bus.fwd1_hit, bus.fwd2_hit}); else n_pass++;
    n_checks++; if (bus.req_ready !== 3'b010) $display("FAIL rst_ready got %b want 010", bus.req_ready); else n_pass++;
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_raw_bypass();
    do_reset();
    drive_iss(1, 1, 5, 1, 2);
    #1;
    n_checks++; if (bus.iss_stall !== 1'b0) $display("FAIL raw_issue_stall got %b want 0", bus.iss_stall); else n_pass++;
    tick();
    drive_iss(1, 0, 0, 5, 0);
    bus.req_valid = 3'b001;
    bus.req_rd    = 15'd5;
    bus.req_data  = {128'd0, 64'hDEAD};
    #1;
    n_checks++; if (bus.iss_stall !== 1'b1) $display("FAIL raw_stall got %b want 1", bus.iss_stall); else n_pass++;
    n_checks++; if (bus.req_ready !== 3'b001) $display("FAIL raw_ready got %b want 001", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    #1;
    n_checks++; if (bus.gpr_wen !== 1'b1) $display("FAIL raw_wen got %b want 1", bus.gpr_wen); else n_pass++;
    n_checks++; if (bus.gpr_waddr !== 5'd5) $display("FAIL raw_waddr got %0d want 5", bus.gpr_waddr); else n_pass++;
    n_checks++; if (bus.gpr_wdata !== 64'hDEAD) $display("FAIL raw_wdata got %h want dead", bus.gpr_wdata); else n_pass++;
    n_checks++; if (bus.iss_stall !== !Byp) $display("FAIL raw_wb_stall got %b want %b", bus.iss_stall, !Byp); else n_pass++;
    n_checks++; if (bus.fwd1_hit !== Byp) $display("FAIL raw_fwd1 got %b want %b", bus.fwd1_hit, Byp); else n_pass++;
    n_checks++; if (bus.fwd2_hit !== 1'b0) $display("FAIL raw_fwd2 got %b want 0", bus.fwd2_hit); else n_pass++;
    n_checks++; if (bus.fwd_data !== (Byp ? 64'hDEAD : 64'd0)) $display("FAIL raw_fwd_data got %h want %h", bus.fwd_data, Byp ? 64'hDEAD : 64'd0); else n_pass++;
    tick();
    n_checks++; if (bus.gpr_wen !== 1'b0) $display("FAIL raw_wen_drop got %b want 0", bus.gpr_wen); else n_pass++;
    n_checks++; if (bus.iss_stall !== 1'b0) $display("FAIL raw_unstall got %b want 0", bus.iss_stall); else n_pass++;
    n_checks++; if (bus.sb_err !== 1'b0) $display("FAIL raw_sb_err got %b want 0", bus.sb_err); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_round_robin();
    logic [63:0] dat [3];
    for (int i = 0; i < 3; i++) dat[i] = {$urandom, $urandom};
    idle();
    bus.req_valid = 3'b111;
    bus.req_rd    = {5'd12, 5'd11, 5'd10};
    bus.req_data  = {dat[2], dat[1], dat[0]};
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (bus.req_ready !== 3'(1 << (k % 3))) $display("FAIL rr_ready[%0d] got %b want %b", k, bus.req_ready, 3'(1 << (k % 3))); else n_pass++;
      tick();
      n_checks++; if (bus.gpr_wen !== 1'b1) $display("FAIL rr_wen[%0d] got %b want 1", k, bus.gpr_wen); else n_pass++;
      n_checks++; if (bus.gpr_waddr !== 5'(10 + k % 3)) $display("FAIL rr_waddr[%0d] got %0d want %0d", k, bus.gpr_waddr, 10 + k % 3); else n_pass++;
      n_checks++; if (bus.gpr_wdata !== dat[k % 3]) $display("FAIL rr_wdata[%0d] got %h want %h", k, bus.gpr_wdata, dat[k % 3]); else n_pass++;
    end
    idle();
  endtask

  task automatic test_rd_zero();
    do_reset();
    drive_iss(1, 1, 9, 0, 0);
    tick();
    idle();
    bus.req_valid = 3'b100;
    bus.req_data  = {64'h1234_5678, 128'd0};
    #1;
    n_checks++; if (bus.req_ready !== 3'b100) $display("FAIL rd0_ready got %b want 100", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    n_checks++; if (bus.gpr_wen !== 1'b0) $display("FAIL rd0_wen got %b want 0", bus.gpr_wen); else n_pass++;
    n_checks++; if (bus.sb_err !== 1'b0) $display("FAIL rd0_sb_err got %b want 0", bus.sb_err); else n_pass++;
    drive_iss(1, 0, 0, 9, 0);
    #1;
    n_checks++; if (bus.iss_stall !== 1'b1) $display("FAIL rd0_busy_kept got %b want 1", bus.iss_stall); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_sb_err();
    do_reset();
    bus.req_valid = 3'b010;
    bus.req_rd    = {5'd0, 5'd7, 5'd0};
    #1;
    n_checks++; if (bus.req_ready !== 3'b010) $display("FAIL err_ready got %b want 010", bus.req_ready); else n_pass++;
    tick();
    idle();
    n_checks++; if (bus.sb_err !== 1'b1) $display("FAIL err_set got %b want 1", bus.sb_err); else n_pass++;
    n_checks++; if (bus.gpr_wen !== 1'b1 || bus.gpr_waddr !== 5'd7) $display("FAIL err_write got wen=%b addr=%0d want wen=1 addr=7", bus.gpr_wen, bus.gpr_waddr); else n_pass++;
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (bus.sb_err !== 1'b1) $display("FAIL err_sticky got %b want 1", bus.sb_err); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus.sb_err !== 1'b0) $display("FAIL err_clear got %b want 0", bus.sb_err); else n_pass++;
  endtask

  task automatic test_waw();
    do_reset();
    drive_iss(1, 1, 3, 0, 0);
    tick();
    bus.req_valid = 3'b001;
    bus.req_rd    = 15'd3;
    bus.req_data  = {128'd0, 64'h0BAD_F00D};
    #1;
    n_checks++; if (bus.iss_stall !== 1'b1) $display("FAIL waw_stall got %b want 1", bus.iss_stall); else n_pass++;
    tick();
    bus.req_valid = '0;
    #1;
    n_checks++; if (bus.gpr_wen !== 1'b1 || bus.gpr_waddr !== 5'd3) $display("FAIL waw_write got wen=%b addr=%0d want wen=1 addr=3", bus.gpr_wen, bus.gpr_waddr); else n_pass++;
    n_checks++; if (bus.iss_stall !== 1'b1) $display("FAIL waw_wb_stall got %b want 1", bus.iss_stall); else n_pass++;
    tick();
    n_checks++; if (bus.iss_stall !== 1'b0) $display("FAIL waw_unstall got %b want 0", bus.iss_stall); else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_iss(1, 1, 4, 0, 0);
    tick();
    drive_iss(1, 1, 6, 0, 0);
    tick();
    idle();
    bus.req_valid = 3'b001;
    bus.req_rd    = 15'd4;
    bus.req_data  = {128'd0, 64'hCAFE};
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    n_checks++; if (bus.gpr_wen !== 1'b1) $display("FAIL mid_accept_wen got %b want 1", bus.gpr_wen); else n_pass++;
    tick();
    rst = 1'b0;
    n_checks++; if (bus.gpr_wen !== 1'b0) $display("FAIL mid_wen got %b want 0", bus.gpr_wen); else n_pass++;
    drive_iss(1, 1, 6, 4, 6);
    bus.req_valid = 3'b011;
    #1;
    n_checks++; if (bus.iss_stall !== 1'b0) $display("FAIL mid_busy_clear got %b want 0", bus.iss_stall); else n_pass++;
    n_checks++; if (bus.req_ready !== 3'b001) $display("FAIL mid_ptr got %b want 001", bus.req_ready); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_random();
    bit          rq_v [3];
    logic [4:0]  rq_rd [3];
    logic [63:0] rq_d [3];
    int          waitc [3];
    int          g, nb;
    logic [4:0]  cands [32];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rq_v[i] = 0; rq_rd[i] = '0; rq_d[i] = '0; waitc[i] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      nb = 0;
      for (int r = 1; r < 32; r++) if (m_busy[r]) begin cands[nb] = 5'(r); nb++; end
      for (int i = 0; i < 3; i++) begin
        if (!rq_v[i] && $urandom_range(0, 2) == 0) begin
          rq_v[i]  = 1'b1;
          rq_rd[i] = (nb > 0 && $urandom_range(0, 3) != 0) ? cands[$urandom_range(0, nb - 1)]
                                                           : 5'($urandom_range(0, 7));
          rq_d[i]  = {$urandom, $urandom};
        end
        bus.req_valid[i]        = rq_v[i];
        bus.req_rd[5*i +: 5]    = rq_rd[i];
        bus.req_data[64*i +: 64] = rq_d[i];
      end
      drive_iss($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7));
      #1;
      g = f_grant();
      n_checks++; if (bus.req_ready !== ((g >= 0) ? 3'(1 << g) : 3'b000)) $display("FAIL rnd_ready[%0d] got %b want %b", cyc, bus.req_ready, (g >= 0) ? 3'(1 << g) : 3'b000); else n_pass++;
      n_checks++; if (bus.iss_stall !== f_stall()) $display("FAIL rnd_stall[%0d] got %b want %b", cyc, bus.iss_stall, f_stall()); else n_pass++;
      n_checks++; if (bus.fwd1_hit !== f_hit(bus.iss_rs1) || bus.fwd2_hit !== f_hit(bus.iss_rs2)) $display("FAIL rnd_fwd[%0d] got %b%b want %b%b", cyc, bus.fwd1_hit, bus.fwd2_hit, f_hit(bus.iss_rs1), f_hit(bus.iss_rs2)); else n_pass++;
      n_checks++; if (bus.fwd_data !== (Byp ? m_wdata : 64'd0)) $display("FAIL rnd_fwd_data[%0d] got %h want %h", cyc, bus.fwd_data, Byp ? m_wdata : 64'd0); else n_pass++;
      for (int i = 0; i < 3; i++) begin
        if (rq_v[i] && g != i) begin
          waitc[i]++;
          n_checks++; if (waitc[i] > 2) $display("FAIL rnd_starve[%0d] req %0d waited %0d want <=2", cyc, i, waitc[i]); else n_pass++;
        end
      end
      tick();
      if (g >= 0) begin
        rq_v[g]  = 1'b0;
        waitc[g] = 0;
      end
      n_checks++; if (bus.gpr_wen !== m_wen) $display("FAIL rnd_wen[%0d] got %b want %b", cyc, bus.gpr_wen, m_wen); else n_pass++;
      n_checks++; if (bus.gpr_waddr !== m_waddr || bus.gpr_wdata !== m_wdata) $display("FAIL rnd_wport[%0d] got %0d/%h want %0d/%h", cyc, bus.gpr_waddr, bus.gpr_wdata, m_waddr, m_wdata); else n_pass++;
      n_checks++; if (bus.sb_err !== m_err) $display("FAIL rnd_sb_err[%0d] got %b want %b", cyc, bus.sb_err, m_err); else n_pass++;
    end
    idle();
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_raw_bypass();
    test_round_robin();
    test_rd_zero();
    test_sb_err();
    test_waw();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
